// File: rtl/dff_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin write arbiter of one shared
// register: the FSM state encoding and the wrapped index increment.
package dff_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  // Wrapped increment with an explicit compare against the last index, so the
  // wrap is correct for any requester count, not only powers of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// Combinational round-robin picker: reports whether any request is pending
// and the index of the first set request found searching upward from ptr,
// wrapping from N-1 back to 0. Has no state, so other arbiters can reuse it.
module rr_pick
  import dff_write_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order starting at ptr; the first hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared W-bit register. Each
// grant takes three cycles: IDLE picks a winner, WRITE loads its word, ACK
// pulses its ack and advances the round-robin pointer past it.
// Optional feature: define DFFARB_QN_EN to add the complementary output q_n.
module dff_write_arbiter
  import dff_write_arbiter_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           busy
`ifdef DFFARB_QN_EN
  ,
  output logic [W-1:0]   q_n
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [W-1:0]     data_q, data_d;

  logic             pickAny;
  logic [IDX_W-1:0] pickIdx;
  logic [W-1:0]     dinArr [N];

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pickAny),
    .idx (pickIdx)
  );

  // Split the packed data bus into one word per requester.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      dinArr[k] = din[k*W +: W];
    end
  end

  // Next-state logic and outputs; outputs decode only from registered state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    data_d  = data_q;
    gnt     = '0;
    ack     = '0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          g_d     = pickIdx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        gnt[g_q] = 1'b1;
        busy     = 1'b1;
        data_d   = dinArr[g_q];
        state_d  = ACK;
      end
      ACK: begin
        ack[g_q] = 1'b1;
        busy     = 1'b1;
        ptr_d    = IDX_W'(next_idx(32'(g_q), 32'(N)));
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, grant index and shared register, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      data_q  <= data_d;
    end
  end

  assign q = data_q;

`ifdef DFFARB_QN_EN
  assign q_n = ~data_q;
`else
  // Complementary output not built in this configuration.
`endif

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter for a single shared W-bit D-flip-flop register. Up to N requesters each present a data word with a req/ack handshake, and the arbiter grants one at a time. The grantee's word is loaded into the register, and the requester receives a one-cycle ack. It sits between multiple producer blocks and one shared state register, which is the single write port for that storage.

## Interface
Parameters:
- N, 4: number of requesters, 2..16
- W, 8: register width
- IDX_W, $clog2(N): grant index width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- req  in  N  per-requester write request; held until ack
- din  in  N*W  packed data, requester i at din[i*W +: W]; stable while req[i]=1
- gnt  out  N  one-hot grant, high only in WRITE state
- ack  out  N  one-hot, one-cycle completion pulse, high only in ACK state
- q  out  W  shared register contents
- busy  out  1  high in WRITE or ACK
- q_n  out  W  ~q; present only with DFFARB_QN_EN

## Operation
- FSM states: IDLE, WRITE, ACK.
  - IDLE: if req != 0, latch the winner index g and go to WRITE; otherwise stay in IDLE.
  - WRITE: q <= din[g]; go to ACK.
  - ACK: ack[g]=1; ptr <= (g+1) mod N; go to IDLE.
- Round-robin selection: the winner is the first set req bit found searching upward from ptr, with wrap from N-1 to 0. ptr resets to 0.
- A single active requester is always granted, regardless of ptr.
- The write is unconditional once in WRITE. Dropping req[g] during WRITE does not abort the write; ack is still issued.
- Requesters must drop req the cycle after seeing ack. Because ptr has advanced past g, that requester cannot starve others even if it re-requests immediately.
- New req edges arriving in WRITE or ACK are not considered until the next IDLE.
- Reset values (rst_n=0 at a rising edge): state=IDLE, ptr=0, g=0, q=0, gnt=0, ack=0, busy=0, q_n=all ones.
- Reset mid-operation: a write in WRITE is abandoned (q cleared) and no ack is issued.
- Widths: ptr and g are IDX_W bits. The wrap uses an explicit compare to N-1, never a natural overflow, so non-power-of-2 N is correct.

## Timing
- Cycle 0: IDLE, req[i] rises and is sampled at the end of cycle 0.
- Cycle 1: WRITE, gnt[i]=1, busy=1. q loads din[i] at the end of cycle 1.
- Cycle 2: ACK, ack[i]=1, q shows the new value, busy=1.
- Cycle 3: IDLE, ready to arbitrate again.
- Latency from req to new q is 2 cycles; from req to ack is 2 cycles.
- Throughput: one write per 3 cycles under continuous contention.
- gnt, ack and busy decode only from registered state, g and ptr. They carry no combinational path from req.

## Configuration
- DFFARB_QN_EN defined: adds output q_n = ~q (complementary register output, combinational from q).
- DFFARB_QN_EN undefined: port q_n is absent. No other behaviour changes.

## Structure
- Package dff_write_arbiter_pkg holds:
  - state enum (IDLE=2'd0, WRITE=2'd1, ACK=2'd2)
  - a function next_idx(idx, n) for the wrapped increment
- Sub-module rr_pick (parameters N, IDX_W) is purely combinational. Inputs: req and ptr. Outputs: any and idx. It is reusable by other arbiters.
- The FSM, the register and the ptr/g registers live in the top module.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with req=4'b1111 → q=0, gnt=0, ack=0, busy=0 throughout; state=IDLE after release.
- Single write: req=4'b0100, din[2]=8'hA5 → gnt=4'b0100 in cycle 1, ack=4'b0100 and q=8'hA5 in cycle 2, idle in cycle 3.
- Contention, full round-robin: hold req=4'b1111 with distinct data, each requester dropping req after its ack and re-raising it 1 cycle later → grant order 0,1,2,3,0, with q matching each grantee in its ACK cycle.
- Wrap and skip, N=3: make requester 2 win, then assert req=3'b011 → requester 0 is granted next (ptr wrapped to 0), then requester 1.
- Req drop during WRITE: deassert req[1] in its WRITE cycle → q still loads din[1] and ack[1] still pulses.
- Reset mid-write: assert rst_n=0 in the WRITE cycle → next cycle q=0, no ack, ptr=0; with DFFARB_QN_EN defined, q_n=8'hFF.
